jpeg_dma_wr: RTL and testbench
==============================

JPEG_DMA_WR -- requirements
Module: jpeg_dma_wr

Interface
REQ-001 Parameter BLOCK_WORDS, default 32: 32-bit words per coded block (64 x 16-bit coefficients, two per word).
REQ-002 Parameter LINE_WORDS, default 8: words written per bus burst before the bus is released.
REQ-003 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 wb_adr_i  input  32  slave register address; only bits [4:2] are decoded.
REQ-006 wb_dat_i  input  32  slave write data.
REQ-007 wb_we_i  input  1  slave write strobe.
REQ-008 dmaen_i  input  1  slave select for this block's register window.
REQ-009 wb_dat_o  output  32  slave read data, combinational from wb_adr_i[4:2].
REQ-010 wbm  wishbone.master  -  master port using adr, dat_o, dat_i, we, sel, stb, cyc and ack.
REQ-011 rd_addr_o  output  5  read address to the coded-output block RAM.
REQ-012 rd_data_i  input  32  block RAM read data, valid one cycle after rd_addr_o.
REQ-013 block_ready_i  input  1  one-cycle pulse: the output RAM holds a complete block.
REQ-014 block_done_o  output  1  one-cycle pulse: the block has been fully written and the RAM may be refilled.

Function
REQ-015 Register writes SHALL occur only when dmaen_i && wb_we_i.
REQ-016 The register map, selected by wb_adr_i[4:2], SHALL be:
- 0: dst_addr, 32 bits, byte address of the first word.
- 1: nblocks, 16 bits, number of blocks to write.
- 2: control, write-only, reads 0; bit0 = start, bit1 = abort.
- 3: status, {blocks_written[15:0], 12'b0, overflow, done, pending, busy}.
- Other offsets SHALL read 0.
REQ-017 The state machine SHALL have the states IDLE, WAITBLK, FETCH, WRITE, RELEASE and LAST.
REQ-018 IDLE: on start with nblocks != 0, the block SHALL load the address counter from dst_addr, clear blocks_written, done and overflow, and go to WAITBLK; start with nblocks == 0 SHALL set done and stay in IDLE.
REQ-019 WAITBLK: when pending == 1 or block_ready_i == 1, the block SHALL clear pending, set rd_addr_o = 0 and go to FETCH.
REQ-020 FETCH: cyc=1, stb=0, lasting exactly one cycle, then WRITE.
REQ-021 WRITE: cyc=1, stb=1, we=1, sel=4'b1111, wbm.dat_o = rd_data_i, with adr, dat_o and rd_addr_o held stable until ack.
REQ-022 On ack in WRITE, the block SHALL advance adr by 4 and rd_addr_o by 1, then:
- last word of the block: go to LAST;
- else, end of a LINE_WORDS group: go to RELEASE;
- else: go to FETCH.
REQ-023 RELEASE: cyc=0, stb=0 for exactly one cycle, then FETCH.
REQ-024 LAST: cyc=0; block_done_o pulses for this one cycle and blocks_written increments.
- If blocks_written+1 == nblocks: set done and go to IDLE.
- Otherwise go to WAITBLK.
REQ-025 The address SHALL continue linearly across blocks and SHALL NOT reload from dst_addr between blocks.
REQ-026 rd_addr_o SHALL wrap from BLOCK_WORDS-1 to 0 at block end.
REQ-027 block_ready_i in any state other than WAITBLK SHALL set pending.
REQ-028 block_ready_i while pending is already 1 SHALL set the sticky overflow bit; pending stays 1.
REQ-029 block_ready_i in IDLE SHALL be ignored.
REQ-030 Abort SHALL force IDLE on the next edge from any state, dropping cyc/stb even while awaiting ack, and clearing pending; blocks_written and dst_addr SHALL be retained.
REQ-031 If start and abort are written together, abort SHALL win.
REQ-032 Start while busy SHALL be ignored.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 done and overflow SHALL be sticky until the next accepted start.
REQ-035 The address counter SHALL be 32 bits and wrap modulo 2^32.

Reset
REQ-036 While rst_ni == 0, asynchronously, the block SHALL enter IDLE and clear all registers and counters.
REQ-037 While rst_ni == 0, all outputs SHALL be 0: cyc, stb, we, sel, adr, dat_o, rd_addr_o, block_done_o and wb_dat_o data fields.
REQ-038 Reset asserted mid-burst SHALL drop cyc on assertion, with no further bus activity after release.

Verification
REQ-039 Single block: dst=0x1000, nblocks=1, start, block_ready pulse, ack in the cycle after each stb -> 32 writes at 0x1000..0x107C carrying RAM words 0..31; cyc low exactly one cycle after words 7, 15 and 23; one block_done_o pulse; status reads 0x0001_0004.
REQ-040 Two blocks, second ready pulse while the first is in WRITE -> pending=1, no overflow; second block written at 0x1080..0x10FC; status reads 0x0002_0004.
REQ-041 Three ready pulses during the first block -> overflow=1; exactly nblocks blocks are still written.
REQ-042 Abort while stb=1 with ack withheld for 5 cycles -> cyc=0 on the next edge; busy=0; no block_done_o pulse.
REQ-043 nblocks=0 then start -> done=1, busy never 1, no bus cycle.
REQ-044 rst_ni low for 1 cycle mid-WRITE -> cyc drops immediately; all status fields read 0.

Source files
------------

// File: rtl/jpeg_dma_wr_if.sv
// Wishbone bus bundle used by the JPEG write DMA.
// The master drives adr/dat_o/we/sel/stb/cyc and receives dat_i/ack.
// Handshake: a word transfers on a rising edge where cyc && stb && ack are
// all high; the master holds adr/dat_o/we/sel/stb stable until that edge.
interface wishbone;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (
    output adr, dat_o, we, sel, stb, cyc,
    input  dat_i, ack
  );

  modport slave (
    input  adr, dat_o, we, sel, stb, cyc,
    output dat_i, ack
  );
endinterface

// File: rtl/jpeg_dma_wr.sv
// JPEG coded-block write DMA.
// Copies complete coded blocks from the output block RAM to memory over a
// Wishbone master port, linearly from a programmed byte address.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wb_adr_i/wb_dat_i/wb_we_i/dmaen_i/wb_dat_o  register slave window
//   wbm                  Wishbone master (write-only bursts of LINE_WORDS)
//   rd_addr_o/rd_data_i  block RAM read port (data one cycle after address)
//   block_ready_i        pulse: RAM holds a complete block
//   block_done_o         pulse: block fully written, RAM may be refilled
//   state_o              current FSM state for debug/observation
// Register map (wb_adr_i[4:2]): 0 dst_addr, 1 nblocks, 2 control (W: bit0
// start, bit1 abort), 3 status {blocks_written, 12'b0, ovf, done, pend, busy}.
module jpeg_dma_wr #(
  parameter int BLOCK_WORDS = 32,
  parameter int LINE_WORDS  = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        dmaen_i,
  output logic [31:0] wb_dat_o,
  wishbone.master     wbm,
  output logic [4:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  input  logic        block_ready_i,
  output logic        block_done_o,
  output logic [2:0]  state_o
);

  localparam int LCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAITBLK = 3'd1,
    S_FETCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_LAST    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] nblk_q, nblk_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [LCW-1:0] line_q, line_d;
  logic [15:0] bw_q, bw_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  logic        reg_wr, start, abort, busy;
  logic [2:0]  reg_sel;
  logic        unused_bits;

  assign reg_sel = wb_adr_i[4:2];
  assign reg_wr  = dmaen_i && wb_we_i;
  // Abort wins over a simultaneous start.
  assign abort   = reg_wr && (reg_sel == 3'd2) && wb_dat_i[1];
  assign start   = reg_wr && (reg_sel == 3'd2) && wb_dat_i[0] && !wb_dat_i[1];
  assign busy    = (state_q != S_IDLE);

  assign unused_bits = &{1'b0, wb_adr_i[31:5], wb_adr_i[1:0], wbm.dat_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      dst_q     <= '0;
      nblk_q    <= '0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      line_q    <= '0;
      bw_q      <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dst_q     <= dst_d;
      nblk_q    <= nblk_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      line_q    <= line_d;
      bw_q      <= bw_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dst_d     = dst_q;
    nblk_d    = nblk_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    line_d    = line_q;
    bw_d      = bw_q;
    pend_d    = pend_q;
    done_d    = done_q;
    ovf_d     = ovf_q;

    if (reg_wr && (reg_sel == 3'd0)) dst_d  = wb_dat_i;
    if (reg_wr && (reg_sel == 3'd1)) nblk_d = wb_dat_i[15:0];

    // A block arriving while one is in flight is remembered once; a second
    // arrival before it is consumed is lost and flagged.
    if (block_ready_i && (state_q != S_IDLE) && (state_q != S_WAITBLK)) begin
      if (pend_q) ovf_d  = 1'b1;
      else        pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (nblk_q != 16'd0) begin
            addr_d  = dst_q;
            bw_d    = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_WAITBLK;
          end else begin
            done_d  = 1'b1;
            ovf_d   = 1'b0;
          end
        end
      end
      S_WAITBLK: begin
        if (pend_q || block_ready_i) begin
          // A fresh pulse arriving while consuming the pending one stays pending.
          pend_d    = pend_q && block_ready_i;
          rd_addr_d = '0;
          line_d    = '0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WRITE;
      S_WRITE: begin
        if (wbm.ack) begin
          addr_d = addr_q + 32'd4;
          if (rd_addr_q == 5'(BLOCK_WORDS - 1)) begin
            rd_addr_d = '0;
            state_d   = S_LAST;
          end else begin
            rd_addr_d = rd_addr_q + 5'd1;
            if (line_q == LCW'(LINE_WORDS - 1)) begin
              line_d  = '0;
              state_d = S_RELEASE;
            end else begin
              line_d  = line_q + 1'b1;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_RELEASE: state_d = S_FETCH;
      S_LAST: begin
        bw_d = bw_q + 16'd1;
        if ((bw_q + 16'd1) == nblk_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAITBLK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end
  end

  assign wbm.cyc   = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign wbm.stb   = (state_q == S_WRITE);
  assign wbm.we    = (state_q == S_WRITE);
  assign wbm.sel   = (state_q == S_WRITE) ? 4'b1111 : 4'b0000;
  assign wbm.adr   = addr_q;
  assign wbm.dat_o = (state_q == S_WRITE) ? rd_data_i : 32'd0;
  assign rd_addr_o    = rd_addr_q;
  assign block_done_o = (state_q == S_LAST);
  assign state_o      = state_q;

  always_comb begin
    wb_dat_o = 32'd0;
    unique case (reg_sel)
      3'd0: wb_dat_o = dst_q;
      3'd1: wb_dat_o = {16'd0, nblk_q};
      3'd3: wb_dat_o = {bw_q, 12'd0, ovf_q, done_q, pend_q, busy};
      default: wb_dat_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_jpeg_dma_wr.sv
module tb_jpeg_dma_wr;
  localparam int BW = 32;
  localparam int LW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat = '0;
  logic        wb_we = 1'b0;
  logic        dmaen = 1'b0;
  logic [31:0] wb_dat_o;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic        block_ready = 1'b0;
  logic        block_done;
  logic [2:0]  state_dbg;

  wishbone wb();
  assign wb.dat_i = 32'd0;
  initial wb.ack = 1'b0;

  jpeg_dma_wr #(.BLOCK_WORDS(BW), .LINE_WORDS(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_we_i(wb_we), .dmaen_i(dmaen),
    .wb_dat_o(wb_dat_o), .wbm(wb),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .block_ready_i(block_ready), .block_done_o(block_done),
    .state_o(state_dbg)
  );

  // scoreboard / reference model state
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] blk_seed [0:7];
  int ram_blk = 0;
  int wr_idx = 0;
  int gap = 0;
  int done_cnt = 0;
  int max_wait = 0;
  int wait_cnt = 0;
  bit ack_en = 1'b1;

  function automatic logic [31:0] word_val(input int b, input int w);
    return blk_seed[b & 7] + 32'(w);
  endfunction

  // Wishbone slave: acks after a random number of wait cycles.
  always @(posedge clk) begin
    #1;
    if (wb.cyc && wb.stb && !wb.ack) begin
      if (wait_cnt > 0) wait_cnt--;
      else if (ack_en) wb.ack = 1'b1;
    end else begin
      wb.ack = 1'b0;
      wait_cnt = $urandom_range(max_wait, 0);
    end
  end

  // Block RAM: contents of the block currently held, refilled on block_done.
  always @(posedge clk) begin
    #1;
    rd_data = word_val(ram_blk, int'(rd_addr));
  end

  // Monitor: every accepted write is checked against the expected stream;
  // the idle gap between words inside a block must follow the line grouping.
  always @(negedge clk) begin
    if (rst_n) begin
      if (block_done) begin
        done_cnt++;
        ram_blk++;
      end
      if (wb.cyc && wb.stb && wb.ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: adr=%h dat=%h, required no write", wb.adr, wb.dat_o);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if ({wb.adr, wb.dat_o} !== e || wb.we !== 1'b1 || wb.sel !== 4'hF) begin
            n_err++;
            $display("FAIL write_data[%0d]: adr=%h dat=%h we=%b sel=%h, required adr=%h dat=%h we=1 sel=f",
                     wr_idx, wb.adr, wb.dat_o, wb.we, wb.sel, e[63:32], e[31:0]);
          end
          if (wr_idx % BW != 0) begin
            int eg;
            eg = (((wr_idx % BW) % LW) == 0) ? 1 : 0;
            n_cmp++;
            if (gap !== eg) begin
              n_err++;
              $display("FAIL cyc_gap[%0d]: %0d idle cycles, required %0d", wr_idx, gap, eg);
            end
          end
        end
        wr_idx++;
        gap = 0;
      end else if (!wb.cyc) begin
        gap++;
      end
    end
  end

  // driver tasks
  task automatic reg_write(input int idx, input logic [31:0] d);
    @(negedge clk);
    wb_adr = 32'(idx) << 2;
    wb_dat = d;
    wb_we = 1'b1;
    dmaen = 1'b1;
    @(negedge clk);
    wb_we = 1'b0;
    dmaen = 1'b0;
  endtask

  task automatic reg_read(input int idx, output logic [31:0] d);
    wb_adr = 32'(idx) << 2;
    #1;
    d = wb_dat_o;
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
  endtask

  task automatic start_run(input logic [31:0] dst, input int nb, input bit zero_seed);
    exp_q.delete();
    for (int b = 0; b < 8; b++) blk_seed[b] = zero_seed ? 32'd0 : $urandom;
    ram_blk = 0;
    wr_idx = 0;
    gap = 0;
    done_cnt = 0;
    for (int n = 0; n < nb * BW; n++)
      exp_q.push_back({dst + 32'(4 * n), word_val(n / BW, n % BW)});
    reg_write(0, dst);
    reg_write(1, 32'(nb));
    reg_write(2, 32'd1);
  endtask

  task automatic wait_stb(input int budget, input string name);
    int c = 0;
    while (!wb.stb) begin
      @(negedge clk);
      c++;
      if (c > budget) begin
        n_cmp++; n_err++;
        $display("FAIL %s_timeout: no stb within %0d cycles, required stb", name, budget);
        break;
      end
    end
  endtask

  task automatic wait_done_cnt(input int n, input int budget, input string name);
    int c = 0;
    while (done_cnt < n) begin
      @(negedge clk);
      c++;
      if (c > budget) begin
        n_cmp++; n_err++;
        $display("FAIL %s_timeout: %0d done pulses, required %0d", name, done_cnt, n);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    int c = 0;
    reg_read(3, s);
    while (s[0]) begin
      @(negedge clk);
      c++;
      reg_read(3, s);
      if (c > budget) begin
        n_cmp++; n_err++;
        $display("FAIL %s_idle_timeout: busy still set, required idle", name);
        break;
      end
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] s;
    reg_read(3, s);
    n_cmp++;
    if (s !== exp) begin
      n_err++;
      $display("FAIL %s_status: got %h, required %h", name, s, exp);
    end
  endtask

  task automatic check_run_end(input string name, input int nb);
    n_cmp++;
    if (wr_idx !== nb * BW || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL %s_count: %0d writes, %0d left, required %0d writes, 0 left",
               name, wr_idx, exp_q.size(), nb * BW);
    end
    n_cmp++;
    if (done_cnt !== nb) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d, required %0d", name, done_cnt, nb);
    end
  endtask

  // test scenarios
  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.dat_o, rd_addr, block_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rd=%h bd=%b, required all 0",
               wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.dat_o, rd_addr, block_done);
    end
    check_status("reset", 32'h0);
    reg_read(0, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL reset_dst: got %h, required 00000000", d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    max_wait = 0;
    start_run(32'h0000_1000, 1, 1'b1);
    pulse_ready();
    wait_done_cnt(1, 500, "single");
    wait_idle(50, "single");
    check_run_end("single", 1);
    check_status("single", 32'h0001_0004);
  endtask

  task automatic test_back_to_back_pending();
    max_wait = 0;
    start_run(32'h0000_1000, 2, 1'b0);
    pulse_ready();
    wait_stb(50, "pend");
    pulse_ready();
    check_status("pend_mid", 32'h0000_0003);
    // start while busy is ignored: the run must keep its linear addresses
    reg_write(0, 32'h0000_5000);
    reg_write(2, 32'd1);
    wait_done_cnt(2, 1000, "pend");
    wait_idle(50, "pend");
    check_run_end("pend", 2);
    check_status("pend_end", 32'h0002_0004);
  endtask

  task automatic test_overflow();
    max_wait = 1;
    start_run(32'hFFFF_FF80, 3, 1'b0);
    pulse_ready();
    wait_stb(50, "ovf");
    repeat (3) pulse_ready();
    check_status("ovf_mid", 32'h0000_000B);
    wait_done_cnt(2, 1500, "ovf");
    pulse_ready();
    wait_done_cnt(3, 1000, "ovf");
    wait_idle(50, "ovf");
    check_run_end("ovf", 3);
    check_status("ovf_end", 32'h0003_000C);
  endtask

  task automatic test_abort();
    logic [31:0] d;
    max_wait = 0;
    ack_en = 1'b0;
    start_run(32'h0000_2000, 1, 1'b0);
    pulse_ready();
    wait_stb(50, "abort");
    repeat (5) @(negedge clk);
    wb_adr = 32'h8;
    wb_dat = 32'h2;
    wb_we = 1'b1;
    dmaen = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
      n_err++;
      $display("FAIL abort_cyc: cyc=%b stb=%b, required 0 0", wb.cyc, wb.stb);
    end
    @(negedge clk);
    wb_we = 1'b0;
    dmaen = 1'b0;
    repeat (3) @(negedge clk);
    check_status("abort", 32'h0000_0000);
    n_cmp++;
    if (done_cnt !== 0 || wr_idx !== 0) begin
      n_err++;
      $display("FAIL abort_activity: done=%0d writes=%0d, required 0 0", done_cnt, wr_idx);
    end
    reg_read(0, d);
    n_cmp++;
    if (d !== 32'h0000_2000) begin
      n_err++;
      $display("FAIL abort_dst: got %h, required 00002000", d);
    end
    exp_q.delete();
    ack_en = 1'b1;
    // start and abort together: abort wins, block stays idle
    reg_write(2, 32'h3);
    repeat (3) @(negedge clk);
    check_status("start_abort", 32'h0000_0000);
  endtask

  task automatic test_zero_blocks();
    logic [31:0] s;
    int busy_seen = 0;
    int cyc_seen = 0;
    reg_write(1, 32'd0);
    reg_write(2, 32'd1);
    for (int i = 0; i < 20; i++) begin
      reg_read(3, s);
      if (s[0]) busy_seen++;
      if (wb.cyc) cyc_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (busy_seen !== 0 || cyc_seen !== 0) begin
      n_err++;
      $display("FAIL zero_activity: busy=%0d cyc=%0d cycles, required 0 0", busy_seen, cyc_seen);
    end
    reg_read(3, s);
    n_cmp++;
    if (s[2:0] !== 3'b100) begin
      n_err++;
      $display("FAIL zero_done: status[2:0]=%b, required 100", s[2:0]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    int cyc_seen = 0;
    max_wait = 2;
    start_run(32'h0000_3000, 1, 1'b0);
    pulse_ready();
    wait_stb(50, "rstmid");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_cyc: cyc=%b stb=%b, required 0 0", wb.cyc, wb.stb);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check_status("rstmid", 32'h0000_0000);
    reg_read(1, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_nblocks: got %h, required 00000000", d);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wb.cyc) cyc_seen++;
    end
    n_cmp++;
    if (cyc_seen !== 0) begin
      n_err++;
      $display("FAIL rstmid_bus: cyc high %0d cycles, required 0", cyc_seen);
    end
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      int nb;
      logic [31:0] dst;
      max_wait = $urandom_range(3, 0);
      nb = $urandom_range(3, 1);
      dst = {$urandom_range(32'hFFFF_FFFF, 0), 2'b00} >> 2 << 2;
      start_run(dst, nb, 1'b0);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(4, 0)) @(negedge clk);
        pulse_ready();
        wait_done_cnt(b + 1, 1500, "rand");
      end
      wait_idle(50, "rand");
      check_run_end("rand", nb);
      check_status("rand", {16'(nb), 16'h0004});
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back_pending();
    test_overflow();
    test_abort();
    test_zero_blocks();
    test_reset_mid_write();
    test_random_runs();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
